// File: rtl/sobel_pkg.sv
// Shared constants, FSM state type and helpers for the Sobel engine.
// The SOBEL_THRESH_EN build option is consumed in sobel_kernel.
package sobel_pkg;

  localparam int unsigned IMG_W       = 320;
  localparam int unsigned IMG_H       = 240;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned FRAME_WORDS = IMG_W * IMG_H;
  localparam int unsigned THRESH      = 128;

  localparam int unsigned SUM_W   = 10;  // p + 2q + r, at most 1020
  localparam int unsigned GRAD_W  = 11;  // signed gradient, +/-1020
  localparam int unsigned MAG_W   = 12;
  localparam int unsigned PIX_MAX = (1 << PIX_W) - 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  function automatic logic [SUM_W-1:0] tap_sum(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b,
                                               input logic [PIX_W-1:0] c);
    return SUM_W'(a) + SUM_W'({b, 1'b0}) + SUM_W'(c);
  endfunction

endpackage

// File: rtl/sobel_wb_engine_if.sv
// Single-word Wishbone-style slave bus of the Sobel engine.
interface sobel_wb_engine_if #(
  parameter int unsigned ADDR_W = 22
);
  logic              cyc_i;
  logic              stb_i;
  logic              we;
  logic [ADDR_W-1:0] adr_in;
  logic [31:0]       dat_in;
  logic [31:0]       dat_out;
  logic              ack_out;

  modport master (output cyc_i, stb_i, we, adr_in, dat_in, input dat_out, ack_out);
  modport slave  (input cyc_i, stb_i, we, adr_in, dat_in, output dat_out, ack_out);
endinterface

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel window to 8-bit result (pRC: row R, column C).
// With SOBEL_THRESH_EN defined the result is binarised against THRESH.
module sobel_kernel
  import sobel_pkg::*;
(
  input  logic [PIX_W-1:0] p00_i,
  input  logic [PIX_W-1:0] p01_i,
  input  logic [PIX_W-1:0] p02_i,
  input  logic [PIX_W-1:0] p10_i,
  input  logic [PIX_W-1:0] p12_i,
  input  logic [PIX_W-1:0] p20_i,
  input  logic [PIX_W-1:0] p21_i,
  input  logic [PIX_W-1:0] p22_i,
  output logic [PIX_W-1:0] res_o
);

  logic signed [GRAD_W-1:0] gx, gy;
  logic        [GRAD_W-1:0] ax, ay;
  logic        [MAG_W-1:0]  mag;

  always_comb begin
    gx  = $signed({1'b0, tap_sum(p02_i, p12_i, p22_i)}) -
          $signed({1'b0, tap_sum(p00_i, p10_i, p20_i)});
    gy  = $signed({1'b0, tap_sum(p20_i, p21_i, p22_i)}) -
          $signed({1'b0, tap_sum(p00_i, p01_i, p02_i)});
    ax  = gx[GRAD_W-1] ? GRAD_W'(-gx) : GRAD_W'(gx);
    ay  = gy[GRAD_W-1] ? GRAD_W'(-gy) : GRAD_W'(gy);
    mag = MAG_W'(ax) + MAG_W'(ay);
`ifdef SOBEL_THRESH_EN
    res_o = (mag >= MAG_W'(THRESH)) ? '1 : '0;
`else
    res_o = (mag > MAG_W'(PIX_MAX)) ? '1 : mag[PIX_W-1:0];
`endif
  end

endmodule

// File: rtl/sobel_wb_engine.sv
// Memory-mapped Sobel engine: bus slave, src/dst frame RAMs and raster-scan FSM.
// Optional binarised output via the SOBEL_THRESH_EN macro (see sobel_kernel).
module sobel_wb_engine
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W  = sobel_pkg::IMG_W,
  parameter int unsigned IMG_H  = sobel_pkg::IMG_H,
  parameter int unsigned ADDR_W = 22
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sobel_wb_engine_if.slave bus,
  input  logic             start,
  output logic             done
);

  localparam int unsigned FRAME = IMG_W * IMG_H;
  localparam int unsigned IDX_W = $clog2(FRAME);
  localparam int unsigned X_W   = $clog2(IMG_W);
  localparam int unsigned Y_W   = $clog2(IMG_H);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   pix_q, rd_addr, bus_idx;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [3:0]         tap_q;
  logic [PIX_W-1:0]   src_mem [FRAME];
  logic [PIX_W-1:0]   dst_mem [FRAME];
  logic [PIX_W-1:0]   win_q   [9];
  logic [PIX_W-1:0]   src_rd_q, dst_rd_q, kern_res;
  logic [ADDR_W-3:0]  word_idx;
  logic               ack_q, hold_q, rd_ok_q;
  logic               req, req_new, in_range, bus_ok, src_we;
  logic               busy, border, last_tap, pix_wr, last_pix;
  logic               unused_bus;

  // Bus slave: one ack per request; a held strobe must drop before the next transfer.
  assign word_idx   = bus.adr_in[ADDR_W-1:2];
  assign bus_idx    = word_idx[IDX_W-1:0];
  assign in_range   = word_idx < (ADDR_W-2)'(FRAME);
  assign req        = bus.cyc_i & bus.stb_i;
  assign req_new    = req & ~ack_q & ~hold_q;
  assign busy       = (state_q == StBusy);
  assign bus_ok     = req_new & in_range & ~busy;
  assign src_we     = bus_ok & bus.we;
  assign unused_bus = ^{bus.adr_in[1:0], bus.dat_in[31:PIX_W]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q   <= 1'b0;
      hold_q  <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      ack_q   <= req_new;
      hold_q  <= req & (hold_q | ack_q);
      rd_ok_q <= bus_ok & ~bus.we;
    end
  end

  assign bus.ack_out = ack_q;
  assign bus.dat_out = rd_ok_q ? {{(32-PIX_W){1'b0}}, dst_rd_q} : '0;

  // Scan: interior pixels take 9 window reads plus one write cycle, borders one cycle.
  assign border   = (x_q == '0) || (x_q == X_W'(IMG_W-1)) ||
                    (y_q == '0) || (y_q == Y_W'(IMG_H-1));
  assign last_tap = border || (tap_q == 4'd10);
  assign pix_wr   = busy && last_tap;
  assign last_pix = (pix_q == IDX_W'(FRAME-1));

  always_comb begin
    rd_addr = '0;
    if (!border && tap_q < 4'd9) begin
      rd_addr = IDX_W'(int'(pix_q) + (int'(tap_q) / 3 - 1) * int'(IMG_W) +
                       int'(tap_q) % 3 - 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pix_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      tap_q <= '0;
    end else if (!busy) begin
      pix_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      tap_q <= '0;
    end else if (last_tap) begin
      tap_q <= '0;
      pix_q <= pix_q + 1'b1;
      if (x_q == X_W'(IMG_W-1)) begin
        x_q <= '0;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end else begin
      tap_q <= tap_q + 1'b1;
    end
  end

  // Read data lags its address by one cycle, so taps 1..9 capture taps 0..8.
  always_ff @(posedge clk_i) begin
    if (busy && tap_q != 4'd0 && tap_q <= 4'd9) begin
      for (int i = 0; i < 8; i++) win_q[i] <= win_q[i+1];
      win_q[8] <= src_rd_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (src_we) src_mem[bus_idx] <= bus.dat_in[PIX_W-1:0];
    src_rd_q <= src_mem[rd_addr];
  end

  always_ff @(posedge clk_i) begin
    if (pix_wr) dst_mem[pix_q] <= border ? '0 : kern_res;
    dst_rd_q <= dst_mem[bus_idx];
  end

  sobel_kernel u_kernel (
    .p00_i (win_q[0]),
    .p01_i (win_q[1]),
    .p02_i (win_q[2]),
    .p10_i (win_q[3]),
    .p12_i (win_q[5]),
    .p20_i (win_q[6]),
    .p21_i (win_q[7]),
    .p22_i (win_q[8]),
    .res_o (kern_res)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StBusy;
      StBusy:  if (pix_wr && last_pix) state_d = StDone;
      StDone:  if (!start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done = (state_q == StDone);
  end

endmodule

// File: tb/tb_sobel_wb_engine.sv
// Directed/random bench for sobel_wb_engine on a reduced 16x12 frame,
// checked against a plain-arithmetic Sobel reference model.
module tb_sobel_wb_engine;

  localparam int W = 16;
  localparam int H = 12;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic start = 1'b0;
  logic done;
  int   checks = 0;
  int   errors = 0;
  int   img [H][W];
  logic [31:0] q;

  sobel_wb_engine_if #(.ADDR_W(22)) bus ();

  sobel_wb_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(22)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus),
    .start (start),
    .done  (done)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int p(input int x, input int y);
    return img[y][x];
  endfunction

  function automatic int ref_out(input int x, input int y);
    int gx, gy, m;
    if (x == 0 || y == 0 || x == W-1 || y == H-1) return 0;
    gx = (p(x+1,y-1) + 2*p(x+1,y) + p(x+1,y+1)) - (p(x-1,y-1) + 2*p(x-1,y) + p(x-1,y+1));
    gy = (p(x-1,y+1) + 2*p(x,y+1) + p(x+1,y+1)) - (p(x-1,y-1) + 2*p(x,y-1) + p(x+1,y-1));
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
    return (m >= 128) ? 255 : 0;
`else
    return (m > 255) ? 255 : m;
`endif
  endfunction

  // One bus transfer; ack must arrive on the first edge after the request.
  task automatic bus_xfer(input logic w, input int widx, input logic [31:0] d,
                          output logic [31:0] rdata);
    int n = 0;
    logic got = 1'b0;
    @(negedge clk_i);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we = w;
    bus.adr_in = 22'(widx * 4); bus.dat_in = d;
    while (!got && n < 8) begin
      @(posedge clk_i); #1;
      n++;
      got = bus.ack_out;
    end
    rdata = bus.dat_out;
    check("ack_latency", 32'(n), 32'd1);
    @(negedge clk_i);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we = 1'b0;
  endtask

  task automatic load_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        bus_xfer(1'b1, y*W + x, 32'hABCD_0000 | 32'(img[y][x]), q);
  endtask

  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 12*W*H + 50 && !seen; i++) begin
      @(posedge clk_i); #1;
      seen = done;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic run_check(input string tag, input bit poke);
    @(negedge clk_i) start = 1'b1;
    if (poke) begin
      repeat (4) @(posedge clk_i);
      bus_xfer(1'b0, W + 1, 32'h0, q);
      check("busy_read_zero", q, 32'h0);
      bus_xfer(1'b1, W + 1, 32'(~img[1][1] & 8'hFF), q);
      check("busy_write_dropped", 32'(dut.src_mem[W+1]), 32'(img[1][1]));
    end
    wait_done({tag, "_done"});
    repeat (3) @(posedge clk_i);
    #1 check({tag, "_no_retrigger"}, 32'(done), 32'd1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        bus_xfer(1'b0, y*W + x, 32'h0, q);
        check($sformatf("%s(%0d,%0d)", tag, x, y), q, 32'(ref_out(x, y)));
      end
    @(negedge clk_i) start = 1'b0;
    @(posedge clk_i); #1;
    check({tag, "_done_clear"}, 32'(done), 32'd0);
  endtask

  initial begin
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we = 1'b0;
    bus.adr_in = '0; bus.dat_in = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_ack", 32'(bus.ack_out), 32'd0);
    check("reset_dat", bus.dat_out, 32'h0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk_i) rst_i = 1'b1;

    // Held strobe: exactly one ack, one cycle after the request.
    @(negedge clk_i);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we = 1'b1; bus.adr_in = '0; bus.dat_in = 32'h5A;
    #1 check("hs_no_comb_ack", 32'(bus.ack_out), 32'd0);
    @(posedge clk_i); #1 check("hs_ack_c1", 32'(bus.ack_out), 32'd1);
    @(posedge clk_i); #1 check("hs_ack_c2", 32'(bus.ack_out), 32'd0);
    @(posedge clk_i); #1 check("hs_ack_c3", 32'(bus.ack_out), 32'd0);
    @(negedge clk_i);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we = 1'b0;
    check("hs_src0", 32'(dut.src_mem[0]), 32'h5A);

    foreach (img[y, x]) img[y][x] = 'h40;
    load_frame();
    run_check("flat", 1'b0);

    foreach (img[y, x]) img[y][x] = (x < W/2) ? 0 : 255;
    load_frame();
    run_check("vstep", 1'b0);

    foreach (img[y, x]) img[y][x] = 0;
    img[10][10] = 100;
    load_frame();
    // Out-of-range write aliases onto index 0 if the range check is missing.
    bus_xfer(1'b1, 'h4B000 >> 2, 32'hFF, q);
    check("oor_write_dropped", 32'(dut.src_mem[0]), 32'h0);
    run_check("impulse", 1'b0);
    bus_xfer(1'b0, 10*W + 9, 32'h0, q);
`ifdef SOBEL_THRESH_EN
    check("impulse_9_10", q, 32'hFF);
`else
    check("impulse_9_10", q, 32'd200);
`endif

    foreach (img[y, x]) img[y][x] = int'($urandom_range(0, 255));
    load_frame();
    run_check("rand_a", 1'b1);
    bus_xfer(1'b0, 'h4B000 >> 2, 32'h0, q);
    check("oor_read_zero", q, 32'h0);
    bus_xfer(1'b0, 256 + W + 1, 32'h0, q);
    check("oor_read_alias_zero", q, 32'h0);

    foreach (img[y, x]) img[y][x] = ($urandom_range(0, 1) != 0) ? 255 : 0;
    load_frame();
    run_check("rand_bin", 1'b0);

    // Reset during the scan, then a clean rerun.
    foreach (img[y, x]) img[y][x] = int'($urandom_range(0, 255));
    load_frame();
    @(negedge clk_i) start = 1'b1;
    repeat (300) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;
    #1;
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_ack", 32'(bus.ack_out), 32'd0);
    check("rst_mid_state", 32'(dut.state_q), 32'(sobel_pkg::StIdle));
    repeat (2) @(negedge clk_i);
    start = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 check("rst_mid_idle", 32'(done), 32'd0);
    run_check("rerun", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
